// File: rtl/sram_stream_reader.sv
// -----------------------------------------------------------------------------
// sram_stream_reader
//
// Drains a block of words from one of the ADC sample SRAM banks (read port 1 of
// a 1rw1r macro) and streams them out on a valid/ready interface.
//
// A start command latches bank, first address and word count. Reads are issued
// one per cycle while the output FIFO has room for every word already in flight.
// The SRAM returns data one cycle after the read is issued, and the word is
// written into the FIFO on the edge after that. Credits are therefore counted
// as FIFO occupancy plus the reads still in the SRAM pipeline (0..2).
//
// Handshake: a beat transfers on a rising clock edge where valid_o and ready_i
// are both high; once valid_o is raised, dat_o and valid_o hold steady until
// that beat is taken.
//
// Ports
//   wb_clk_i       clock (also drives the SRAM read-port clock)
//   wb_rst_ni      asynchronous active-low reset
//   start_i        start pulse, sampled only while idle
//   abort_i        cancels a transfer in progress (wins over start_i)
//   bank_i         bank select, latched on start (out of range -> bank 0)
//   start_addr_i   first read address, latched on start
//   count_i        number of words to read, 0 means 2**ADDR_W
//   mem_renb_o     per-bank active-low read enable (csb1)
//   mem_raddr_o    shared read address (addr1)
//   mem0_data_i    dout1 of bank 0
//   mem1_data_i    dout1 of bank 1
//   dat_o          stream data (registered FIFO head)
//   valid_o        stream valid
//   ready_i        stream ready
//   busy_o         transfer in progress
//   done_o         one-cycle pulse after the last beat was accepted
//   state_o        FSM state, for debug and assertion binding
// -----------------------------------------------------------------------------
module sram_stream_reader #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 9,
  parameter int NBANKS     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              bank_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W:0]   count_i,
  output logic [NBANKS-1:0] mem_renb_o,
  output logic [ADDR_W-1:0] mem_raddr_o,
  input  logic [DATA_W-1:0] mem0_data_i,
  input  logic [DATA_W-1:0] mem1_data_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic                bank_q, bank_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     rem_q, rem_d;
  logic [NBANKS-1:0]   renb_q, renb_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                iss_q, iss_d;   // read issued last edge, SRAM samples it next edge
  logic                rdv_q, rdv_d;   // SRAM dout valid this cycle, FIFO write next edge
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                valid_q, valid_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                bank_sel;
  logic [ADDR_W:0]     start_words;
  logic [CNT_W:0]      occ;
  logic                credit_ok;
  logic                flush;
  logic                pop;
  logic                fifo_we;
  logic [DATA_W-1:0]   wdata;
  logic                after_pop_empty;
  logic [DATA_W-1:0]   next_head;

  assign bank_sel    = ({31'd0, bank_i} < 32'(NBANKS)) ? bank_i : 1'b0;
  assign start_words = (count_i == '0) ? {1'b1, {ADDR_W{1'b0}}} : count_i;

  // Words the FIFO must be able to take: already stored plus still in flight.
  assign occ       = (CNT_W+1)'(cnt_q) + (CNT_W+1)'(iss_q) + (CNT_W+1)'(rdv_q);
  assign credit_ok = occ < (CNT_W+1)'(FIFO_DEPTH);

  assign flush   = abort_i && (state_q != ST_IDLE);
  assign pop     = valid_q && ready_i;
  assign fifo_we = rdv_q && !flush;
  assign wdata   = bank_q ? mem1_data_i : mem0_data_i;

  // When the FIFO is (or becomes) empty the incoming word goes straight to the
  // head register; otherwise the head is the stored entry at the next read ptr.
  assign after_pop_empty = (cnt_q == '0) || ((cnt_q == CNT_W'(1)) && pop);

  always_comb begin
    next_head = fifo_mem_q[rd_ptr_d];
    if (after_pop_empty) begin
      next_head = wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM, read issue and FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    renb_d   = '1;
    raddr_d  = raddr_q;
    iss_d    = 1'b0;
    rdv_d    = iss_q;
    done_d   = 1'b0;
    wr_ptr_d = wr_ptr_q + PTR_W'(fifo_we);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q + CNT_W'(fifo_we) - CNT_W'(pop);
    valid_d  = (cnt_d != '0);
    dat_d    = dat_q;
    if (cnt_d != '0) begin
      dat_d = next_head;
    end

    unique case (state_q)
      ST_IDLE: begin
        // The FIFO is empty when idle, so the first read goes out on the
        // same edge that accepts the command.
        if (start_i && !abort_i) begin
          bank_d           = bank_sel;
          renb_d[bank_sel] = 1'b0;
          raddr_d          = start_addr_i;
          iss_d            = 1'b1;
          addr_d           = start_addr_i + ADDR_W'(1);
          rem_d            = start_words - (ADDR_W+1)'(1);
          state_d          = (start_words == (ADDR_W+1)'(1)) ? ST_DRAIN : ST_READ;
        end
      end

      ST_READ: begin
        if (rem_q == '0) begin
          state_d = ST_DRAIN;
        end else if (credit_ok) begin
          renb_d[bank_q] = 1'b0;
          raddr_d        = addr_q;
          iss_d          = 1'b1;
          addr_d         = addr_q + ADDR_W'(1);
          rem_d          = rem_q - (ADDR_W+1)'(1);
          if (rem_q == (ADDR_W+1)'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        // Last beat: nothing in flight and the only stored word leaves now.
        if (pop && (cnt_q == CNT_W'(1)) && !iss_q && !rdv_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort: drop everything in flight and empty the FIFO.
    if (flush) begin
      state_d  = ST_IDLE;
      renb_d   = '1;
      iss_d    = 1'b0;
      rdv_d    = 1'b0;
      rem_d    = '0;
      done_d   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      valid_d  = 1'b0;
      dat_d    = dat_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q  <= ST_IDLE;
      bank_q   <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      renb_q   <= '1;
      raddr_q  <= '0;
      iss_q    <= 1'b0;
      rdv_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dat_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      renb_q   <= renb_d;
      raddr_q  <= raddr_d;
      iss_q    <= iss_d;
      rdv_q    <= rdv_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      dat_q    <= dat_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  // FIFO storage needs no reset: entries are only read after being written.
  always_ff @(posedge wb_clk_i) begin
    if (fifo_we) begin
      fifo_mem_q[wr_ptr_q] <= wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign mem_renb_o  = renb_q;
  assign mem_raddr_o = raddr_q;
  assign dat_o       = dat_q;
  assign valid_o     = valid_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_sram_stream_reader.sv
// -----------------------------------------------------------------------------
// Bench for sram_stream_reader: two SRAM bank models with 1-cycle read latency,
// an expected-word queue built from the bank contents, and per-scenario tasks.
// -----------------------------------------------------------------------------
module tb_sram_stream_reader;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int NB = 2;
  localparam int FD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic          bank_i = 1'b0;
  logic [AW-1:0] start_addr_i = '0;
  logic [AW:0]   count_i = '0;
  logic [NB-1:0] mem_renb;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem0_data = '0;
  logic [DW-1:0] mem1_data = '0;
  logic [DW-1:0] dat_o;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic          busy_o;
  logic          done_o;
  logic [1:0]    state_dbg;

  sram_stream_reader #(.DATA_W(DW), .ADDR_W(AW), .NBANKS(NB), .FIFO_DEPTH(FD)) dut (
    .wb_clk_i     (clk),
    .wb_rst_ni    (rst_n),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .bank_i       (bank_i),
    .start_addr_i (start_addr_i),
    .count_i      (count_i),
    .mem_renb_o   (mem_renb),
    .mem_raddr_o  (mem_raddr),
    .mem0_data_i  (mem0_data),
    .mem1_data_i  (mem1_data),
    .dat_o        (dat_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .state_o      (state_dbg)
  );

  // ---------------- SRAM models ----------------
  logic [DW-1:0] m0 [512];
  logic [DW-1:0] m1 [512];

  // Read port samples csb1/addr1 on the edge; dout is garbage when not enabled
  // so a mistimed capture shows up as wrong data.
  always @(posedge clk) begin
    mem0_data <= (!mem_renb[0]) ? m0[mem_raddr] : $urandom();
    mem1_data <= (!mem_renb[1]) ? m1[mem_raddr] : $urandom();
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [DW-1:0] exp_q[$];

  int r_beats, r_dones, r_first_valid, r_last_beat, r_done_cyc, r_issues;

  // Drives one transfer and checks every stream beat, every read issue and
  // the completion handshake against the reference built from bank contents.
  task automatic run_xfer(input logic b, input logic [AW-1:0] a, input logic [AW:0] c,
                          input bit rnd, input int abort_beat, input bit stray);
    int n, cyc, iss, beats;
    bit done_seen, held, r;
    logic [DW-1:0] held_dat, got;
    logic [AW-1:0] ea;
    logic [NB-1:0] exp_renb;
    n = (c == 0) ? 512 : int'(c);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      ea = AW'((int'(a) + i) % 512);
      exp_q.push_back(b ? m1[ea] : m0[ea]);
    end
    exp_renb = b ? 2'b01 : 2'b10;
    cyc = 0; iss = 0; beats = 0; done_seen = 0; held = 0; held_dat = '0;
    r_first_valid = -1; r_last_beat = -1; r_done_cyc = -1;
    bank_i = b; start_addr_i = a; count_i = c; start_i = 1'b1;
    while (1) begin
      @(negedge clk);
      cyc++;
      start_i = 1'b0;
      if (stray && cyc == 2) begin
        start_i = 1'b1; bank_i = ~b; start_addr_i = a + AW'(100); count_i = 10'd3;
      end
      if (cyc > 6 * n + 60) begin
        total++; bad++;
        $display("FAIL timeout: cycles=%0d beats=%0d required=%0d", cyc, beats, n);
        break;
      end
      if (done_seen) begin
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || mem_renb !== 2'b11) begin
          bad++;
          $display("FAIL post_done: busy=%b done=%b renb=%b required 0 0 11", busy_o, done_o, mem_renb);
        end
        break;
      end
      if (done_o === 1'b1) begin
        done_seen = 1; r_done_cyc = cyc;
        total++;
        if (beats != n || exp_q.size() != 0) begin
          bad++;
          $display("FAIL done_early: beats=%0d required=%0d left=%0d", beats, n, exp_q.size());
        end
      end else begin
        total++;
        if (busy_o !== 1'b1) begin
          bad++;
          $display("FAIL busy: got=%b required=1 cyc=%0d", busy_o, cyc);
        end
      end
      if (held) begin
        total++;
        if (valid_o !== 1'b1 || dat_o !== held_dat) begin
          bad++;
          $display("FAIL hold: valid=%b dat=%h required 1 %h", valid_o, dat_o, held_dat);
        end
      end
      if (mem_renb !== 2'b11) begin
        ea = AW'((int'(a) + iss) % 512);
        total++;
        if (mem_renb !== exp_renb || mem_raddr !== ea) begin
          bad++;
          $display("FAIL issue: renb=%b raddr=%0d required %b %0d", mem_renb, mem_raddr, exp_renb, ea);
        end
        iss++;
        total++;
        if (iss - beats > FD || iss > n) begin
          bad++;
          $display("FAIL credit: outstanding=%0d required<=%0d issued=%0d", iss - beats, FD, iss);
        end
      end
      if (abort_beat >= 0 && beats == abort_beat) begin
        ready_i = 1'b0; abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        total++;
        if (valid_o !== 1'b0 || busy_o !== 1'b0 || mem_renb !== 2'b11 || done_o !== 1'b0) begin
          bad++;
          $display("FAIL abort: valid=%b busy=%b renb=%b done=%b required 0 0 11 0",
                   valid_o, busy_o, mem_renb, done_o);
        end
        ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          total++;
          if (done_o !== 1'b0 || valid_o !== 1'b0 || mem_renb !== 2'b11) begin
            bad++;
            $display("FAIL abort_quiet: done=%b valid=%b renb=%b", done_o, valid_o, mem_renb);
          end
        end
        r_beats = beats; r_dones = 0; r_issues = iss;
        return;
      end
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ready_i = r;
      held = (valid_o === 1'b1) && !r;
      held_dat = dat_o;
      if (valid_o === 1'b1 && r_first_valid < 0) r_first_valid = cyc;
      if (valid_o === 1'b1 && r) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: dat=%h required none", dat_o);
        end else begin
          got = exp_q.pop_front();
          if (dat_o !== got) begin
            bad++;
            $display("FAIL beat%0d: dat=%h required=%h", beats, dat_o, got);
          end
        end
        beats++;
        r_last_beat = cyc;
      end
    end
    ready_i = 1'b1;
    r_beats = beats; r_dones = done_seen ? 1 : 0; r_issues = iss;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    @(negedge clk);
    total++;
    if (mem_renb !== 2'b11 || mem_raddr !== '0 || dat_o !== '0 || valid_o !== 1'b0 ||
        busy_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL reset: renb=%b raddr=%0d dat=%h valid=%b busy=%b done=%b",
               mem_renb, mem_raddr, dat_o, valid_o, busy_o, done_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_linear;
    run_xfer(1'b0, 9'd0, 10'd8, 0, -1, 0);
    total++;
    if (r_first_valid != 3) begin
      bad++; $display("FAIL first_valid: cyc=%0d required=3", r_first_valid);
    end
    total++;
    if (r_beats != 8 || r_last_beat - r_first_valid != 7) begin
      bad++; $display("FAIL throughput: beats=%0d span=%0d required 8 7", r_beats, r_last_beat - r_first_valid);
    end
    total++;
    if (r_dones != 1 || r_done_cyc != r_last_beat + 1) begin
      bad++; $display("FAIL done_timing: dones=%0d cyc=%0d required 1 %0d", r_dones, r_done_cyc, r_last_beat + 1);
    end
  endtask

  task automatic test_wrap;
    run_xfer(1'b1, 9'd510, 10'd4, 0, -1, 0);
    total++;
    if (r_beats != 4 || r_issues != 4 || r_dones != 1) begin
      bad++; $display("FAIL wrap: beats=%0d issues=%0d dones=%0d required 4 4 1", r_beats, r_issues, r_dones);
    end
  endtask

  task automatic test_backpressure;
    for (int t = 0; t < 3; t++) begin
      run_xfer(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)), 10'd16, 1, -1, 0);
      total++;
      if (r_beats != 16 || r_dones != 1) begin
        bad++; $display("FAIL backpressure: beats=%0d dones=%0d required 16 1", r_beats, r_dones);
      end
    end
  endtask

  task automatic test_full_count;
    run_xfer(1'b1, 9'($urandom_range(0, 511)), 10'd0, 0, -1, 0);
    total++;
    if (r_beats != 512 || r_dones != 1) begin
      bad++; $display("FAIL count0: beats=%0d dones=%0d required 512 1", r_beats, r_dones);
    end
  endtask

  task automatic test_abort;
    run_xfer(1'b0, 9'd40, 10'd20, 0, 5, 0);
    total++;
    if (r_beats != 5) begin
      bad++; $display("FAIL abort_beats: beats=%0d required 5", r_beats);
    end
    run_xfer(1'b1, 9'd7, 10'd6, 1, -1, 0);
    total++;
    if (r_beats != 6 || r_dones != 1) begin
      bad++; $display("FAIL after_abort: beats=%0d dones=%0d required 6 1", r_beats, r_dones);
    end
  endtask

  task automatic test_reset_mid;
    bank_i = 1'b0; start_addr_i = 9'd20; count_i = 10'd50; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (mem_renb !== 2'b11 || mem_raddr !== '0 || dat_o !== '0 || valid_o !== 1'b0 ||
        busy_o !== 1'b0 || done_o !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: renb=%b raddr=%0d dat=%h valid=%b busy=%b done=%b",
               mem_renb, mem_raddr, dat_o, valid_o, busy_o, done_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // start together with abort while idle must be ignored
    start_i = 1'b1; abort_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0; abort_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (busy_o !== 1'b0 || mem_renb !== 2'b11 || valid_o !== 1'b0) begin
        bad++; $display("FAIL start_abort_idle: busy=%b renb=%b valid=%b", busy_o, mem_renb, valid_o);
      end
      @(negedge clk);
    end
    // a second start while busy must not disturb the running transfer
    run_xfer(1'b0, 9'd300, 10'd10, 1, -1, 1);
    total++;
    if (r_beats != 10 || r_dones != 1) begin
      bad++; $display("FAIL start_while_busy: beats=%0d dones=%0d required 10 1", r_beats, r_dones);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin
      m0[i] = DW'(i);
      m1[i] = $urandom();
    end
    test_reset();
    test_linear();
    test_wrap();
    test_backpressure();
    test_full_count();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
